// File: rtl/bcla_add_pipe.sv
// Pipelined block-carry-lookahead add/sub; WIDTH split into STAGES segments of 4-bit CLA groups.
// Latency STAGES cycles; valid/ready per stage, bubbles collapse, stalled stages hold their registers.
// Optional BCLA_ADD_PIPE_SAT_EN: saturate sum to the signed extreme on overflow (last stage, no added latency).
module bcla_add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NG   = SEG / 4;
  localparam int LAST = STAGES - 1;

  // Returns {carry into segment MSB, carry out of segment, segment sum}.
  // Every carry is a flat sum of generate/propagate products; nothing ripples between groups.
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
    logic [SEG-1:0] g, p, s;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    gc;
    logic           acc, prod, c_msb;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gg    = '0;
    gp    = '0;
    gc    = '0;
    c_msb = 1'b0;
    for (int j = 0; j < NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int m = 3; m >= 0; m--) begin
        acc  = acc | (prod & g[4*j+m]);
        prod = prod & p[4*j+m];
      end
      gg[j] = acc;
      gp[j] = prod;
    end
    gc[0] = c0;
    for (int j = 0; j < NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int i = j; i >= 0; i--) begin
        acc  = acc | (prod & gg[i]);
        prod = prod & gp[i];
      end
      gc[j+1] = acc | (prod & c0);
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          acc  = acc | (prod & g[4*j+m]);
          prod = prod & p[4*j+m];
        end
        acc        = acc | (prod & gc[j]);
        s[4*j+i]   = p[4*j+i] ^ acc;
        if ((j == NG - 1) && (i == 3)) c_msb = acc;
      end
    end
    return {c_msb, gc[NG], s};
  endfunction

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_x [STAGES];
  logic [WIDTH-1:0]  b_x [STAGES];
  logic [WIDTH-1:0]  s_x [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic [STAGES-1:0] c_x, v_x, c_n;
  logic [STAGES-1:0] ld;
  logic              ovf_n;

  // A stage may load unless it and every stage downstream of it is full while the sink stalls.
  always_comb begin : load_ctrl
    logic full;
    full = 1'b1;
    ld   = '0;
    for (int k = LAST; k >= 0; k--) begin
      full  = full & v_q[k];
      ld[k] = out_ready | ~full;
    end
  end

  always_comb begin : datapath
    logic [SEG+1:0] r;
    r     = '0;
    c_x   = '0;
    v_x   = '0;
    c_n   = '0;
    ovf_n = 1'b0;
    a_x[0] = a;
    b_x[0] = sub ? ~b : b;
    c_x[0] = sub | c_in;
    s_x[0] = '0;
    v_x[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      c_x[k] = c_q[k-1];
      s_x[k] = s_q[k-1];
      v_x[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r                      = seg_add(a_x[k][k*SEG +: SEG], b_x[k][k*SEG +: SEG], c_x[k]);
      s_n[k]                 = s_x[k];
      s_n[k][k*SEG +: SEG]   = r[SEG-1:0];
      c_n[k]                 = r[SEG];
    end
    // r still holds the last segment here.
    ovf_n = r[SEG+1] ^ r[SEG];
`ifdef BCLA_ADD_PIPE_SAT_EN
    if (ovf_n) begin
      s_n[LAST] = a_x[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_x[k];
          a_q[k] <= a_x[k];
          b_q[k] <= b_x[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
        end
      end
      if (ld[LAST]) ovf_q <= ovf_n;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcla_add_pipe.sv
// Randomised and directed bench for bcla_add_pipe at 32/2 and 64/4, scored against an arithmetic model.
module tb_bcla_add_pipe;
  localparam int W = 32, S = 2, W2 = 64, S2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          iv, ir, ci, sb, ov32, ordy, co, of;
  logic [W-1:0]  a32, b32, sum32;
  logic          iv2, ir2, ci2, sb2, ov64, ordy2, co2, of2;
  logic [W2-1:0] a64, b64, sum64;

  bcla_add_pipe #(.WIDTH(W), .STAGES(S)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a32), .b(b32), .c_in(ci), .sub(sb),
    .out_valid(ov32), .out_ready(ordy), .sum(sum32), .c_out(co), .ovf(of));

  bcla_add_pipe #(.WIDTH(W2), .STAGES(S2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a64), .b(b64), .c_in(ci2), .sub(sb2),
    .out_valid(ov64), .out_ready(ordy2), .sum(sum64), .c_out(co2), .ovf(of2));

  typedef struct packed {logic [63:0] s; logic co; logic ov;} res_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain w-bit arithmetic: result, carry out, and signed overflow from operand/result signs.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic cin,
                                 input logic su, input int w);
    logic [64:0] mask, be, full;
    logic        sa, sbe;
    res_t        r;
    mask = (65'd1 << w) - 65'd1;
    be   = su ? (~{1'b0, y} & mask) : {1'b0, y};
    full = {1'b0, x} + be + (su ? 65'd1 : {64'd0, cin});
    r.s  = full[63:0] & mask[63:0];
    r.co = full[w];
    sa   = x[w-1];
    sbe  = be[w-1];
    r.ov = (sa == sbe) && (r.s[w-1] != sa);
`ifdef BCLA_ADD_PIPE_SAT_EN
    if (r.ov) r.s = sa ? (64'd1 << (w - 1)) : (mask[63:0] >> 1);
`endif
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: record accepted beats, check each transferred result and stall stability.
  res_t        q32[$], q64[$];
  res_t        e;
  logic        hold32;
  logic [31:0] hs32;
  logic [1:0]  hf32;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      q32.delete();
      q64.delete();
      hold32 = 1'b0;
    end else begin
      if (hold32) begin
        chk("hold_valid", ov32, 1);
        chk("hold_sum", sum32, hs32);
        chk("hold_flags", {co, of}, hf32);
      end
      hold32 = ov32 && !ordy;
      hs32   = sum32;
      hf32   = {co, of};
      if (ov32 && ordy) begin
        if (q32.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out32_unexpected: got sum %h with no beat outstanding", sum32);
        end else begin
          e = q32.pop_front();
          chk("sum32", sum32, e.s);
          chk("cout32", co, e.co);
          chk("ovf32", of, e.ov);
        end
      end
      if (iv && ir) q32.push_back(model({32'd0, a32}, {32'd0, b32}, ci, sb, W));
      if (ov64 && ordy2) begin
        if (q64.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out64_unexpected: got sum %h with no beat outstanding", sum64);
        end else begin
          e = q64.pop_front();
          chk("sum64", sum64, e.s);
          chk("cout64", co2, e.co);
          chk("ovf64", of2, e.ov);
        end
      end
      if (iv2 && ir2) q64.push_back(model(a64, b64, ci2, sb2, W2));
    end
  end

  task automatic dir32(input string nm, input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic su, input logic [31:0] es, input logic eco, input logic eov);
    int n;
    a32 = x; b32 = y; ci = c; sb = su; ordy = 1'b1; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    n  = 1;
    while (!ov32 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, S);
    chk({nm, "_sum"}, sum32, es);
    chk({nm, "_cout"}, co, eco);
    chk({nm, "_ovf"}, of, eov);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int k;
    iv = 1'b0; iv2 = 1'b0; ordy = 1'b1; ordy2 = 1'b1;
    k = 0;
    while ((q32.size() != 0 || q64.size() != 0) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_q32_empty"}, q32.size(), 0);
    chk({nm, "_q64_empty"}, q64.size(), 0);
  endtask

  initial begin
    res_t        m;
    logic [31:0] e_pos, e_neg;
    logic [3:0]  pat;
    logic        acc, pend, pend2;
    int          sent, cyc, n, acc_cnt;

    rst = 1'b1;
    iv = 1'b0; a32 = '0; b32 = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
    iv2 = 1'b0; a64 = '0; b64 = '0; ci2 = 1'b0; sb2 = 1'b0; ordy2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", ov32, 0);
    chk("rst_in_ready", ir, 1);
    chk("rst_sum", sum32, 0);
    chk("rst_flags", {co, of}, 0);
    chk("rst_out_valid64", ov64, 0);
    chk("rst_in_ready64", ir2, 1);

    m = model(64'h0000_FFFF, 64'd1, 1'b0, 1'b0, 32);
    chk("model_pin_add", {m.s, m.co, m.ov}, {64'h0001_0000, 2'b00});
    m = model(64'd5, 64'd7, 1'b0, 1'b1, 32);
    chk("model_pin_sub", {m.s, m.co}, {64'hFFFF_FFFE, 1'b0});

`ifdef BCLA_ADD_PIPE_SAT_EN
    e_pos = 32'h7FFF_FFFF;
    e_neg = 32'h8000_0000;
`else
    e_pos = 32'h8000_0000;
    e_neg = 32'h7FFF_FFFF;
`endif
    dir32("seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    dir32("all_ones",  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0);
    dir32("sub_neg",   32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    dir32("sub_pos",   32'd7,         32'd5,         1'b1, 1'b1, 32'd2,         1'b1, 1'b0);
    dir32("ovf_pos",   32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, e_pos,         1'b0, 1'b1);
    dir32("ovf_neg",   32'h8000_0000, 32'd1,         1'b0, 1'b1, e_neg,         1'b1, 1'b1);

    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd1; ci2 = 1'b0; sb2 = 1'b0; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    n = 1;
    while (!ov64 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w64_latency", n, S2);
    chk("w64_sum", sum64, 0);
    chk("w64_cout", co2, 1);
    chk("w64_ovf", of2, 0);
    @(posedge clk); #1;

    // Back-to-back beats with an always-ready sink never see in_ready drop.
    ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a32 = rnd32(); b32 = rnd32(); ci = 1'($urandom); sb = 1'($urandom); iv = 1'b1;
      @(negedge clk);
      chk("tput_in_ready", ir, 1);
      @(posedge clk); #1;
    end
    drain("tput");

    pat = 4'b1001;
    sent = 0; cyc = 0;
    a32 = rnd32(); b32 = rnd32(); ci = 1'($urandom); sb = 1'b0;
    while (sent < 8 && cyc < 100) begin
      ordy = pat[cyc % 4];
      iv   = 1'b1;
      @(negedge clk);
      acc = iv && ir;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        a32 = rnd32(); b32 = rnd32(); ci = 1'($urandom);
      end
      cyc++;
    end
    chk("bp_beats_sent", sent, 8);
    drain("bp");

    // Sink stalled from an empty pipe: exactly STAGES beats fit before in_ready falls.
    ordy = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || acc) begin
        a32 = rnd32(); b32 = rnd32(); ci = 1'($urandom); sb = 1'($urandom);
      end
      iv = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", ir, (acc_cnt < S) ? 1 : 0);
      acc = ir;
      if (ir) acc_cnt++;
      @(posedge clk); #1;
    end
    drain("stall");

    ordy = 1'b1;
    a32 = rnd32(); b32 = rnd32(); iv = 1'b1;
    @(posedge clk); #1;
    a32 = rnd32(); b32 = rnd32();
    @(posedge clk); #1;
    iv = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", ov32, 0);
    chk("midrst_in_ready", ir, 1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", ov32, 0);
    end
    @(posedge clk); #1;

    pend = 1'b0; pend2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        iv = ($urandom_range(0, 3) != 0);
        a32 = rnd32(); b32 = rnd32(); ci = 1'($urandom); sb = 1'($urandom);
      end
      if (!pend2) begin
        iv2 = 1'($urandom);
        a64 = {rnd32(), rnd32()}; b64 = {rnd32(), rnd32()}; ci2 = 1'($urandom); sb2 = 1'($urandom);
      end
      ordy  = ($urandom_range(0, 2) != 0);
      ordy2 = 1'($urandom);
      @(negedge clk);
      pend  = iv && !ir;
      pend2 = iv2 && !ir2;
      @(posedge clk); #1;
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
